// File: rtl/alu_pkg.sv
// Shared opcode, sequencer-state and opcode-class definitions for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_INC  = 4'd2;
  localparam logic [3:0] OP_EQ   = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_NAND = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12;
  localparam logic [3:0] OP_ROR  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  typedef enum logic [2:0] {
    CLS_ARITH   = 3'd0,
    CLS_CMP     = 3'd1,
    CLS_SHIFT   = 3'd2,
    CLS_LOGIC   = 3'd3,
    CLS_ROT     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

endpackage

// File: rtl/alu_op_classify.sv
// Combinational opcode decoder: class plus iteration / feedback-target flags.
module alu_op_classify
  import alu_pkg::*;
(
  input  logic [3:0] op,
  output op_class_e  op_class,
  output logic       is_iter,
  output logic       feeds_a,
  output logic       feeds_b
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (op)
      OP_ADD, OP_SUB, OP_INC:          op_class = CLS_ARITH;
      OP_EQ:                           op_class = CLS_CMP;
      OP_SHL, OP_SHR:                  op_class = CLS_SHIFT;
      OP_NOT, OP_AND, OP_OR, OP_NAND:  op_class = CLS_LOGIC;
      OP_ROL, OP_ROR:                  op_class = CLS_ROT;
      default:                         op_class = CLS_ILLEGAL;
    endcase
  end

  // Shifts operate on B, rotates on A; the result is fed back into that operand.
  assign feeds_b = (op_class == CLS_SHIFT);
  assign feeds_a = (op_class == CLS_ROT);
  assign is_iter = feeds_a | feeds_b;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the external 8-bit ALU: accepts a command, iterates shift/rotate passes, returns a registered response.
// Optional sticky overflow flag enabled by defining ALU_CMD_SEQ_STICKY_OVF_EN.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; a valid side holds its payload until then.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [3:0]       alu_op,
  input  logic [W-1:0]     alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_ovf,
  output logic             rsp_err,
`ifdef ALU_CMD_SEQ_STICKY_OVF_EN
  output logic             ovf_sticky,
  input  logic             ovf_clr,
`endif
  output logic [1:0]       state_dbg
);

  seq_state_e       state, state_nx;
  op_class_e        cmd_class;
  logic             cmd_iter, cmd_feeds_a, cmd_feeds_b, cmd_illegal;
  logic [W-1:0]     a_q, b_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             feed_a_q, feed_b_q;

  alu_op_classify u_classify (
    .op       (cmd_op),
    .op_class (cmd_class),
    .is_iter  (cmd_iter),
    .feeds_a  (cmd_feeds_a),
    .feeds_b  (cmd_feeds_b)
  );

  assign cmd_illegal = (cmd_class == CLS_ILLEGAL);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nx = cmd_illegal ? ST_RESP : ST_EXEC;
      ST_EXEC: if (cnt_q == '0) state_nx = ST_RESP;
      ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Ready is masked by reset so nothing is accepted while rst_n is low.
  assign cmd_ready = rst_n && (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign state_dbg = state;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      feed_a_q   <= 1'b0;
      feed_b_q   <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            a_q      <= cmd_a;
            b_q      <= cmd_b;
            cnt_q    <= cmd_iter ? cmd_cnt : '0;
            feed_a_q <= cmd_feeds_a;
            feed_b_q <= cmd_feeds_b;
            if (cmd_illegal) begin
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_neg    <= 1'b0;
              rsp_ovf    <= 1'b0;
              rsp_err    <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_q != '0) begin
            if (feed_b_q) b_q <= alu_result;
            if (feed_a_q) a_q <= alu_result;
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_neg    <= alu_neg;
            rsp_ovf    <= alu_ovf;
            rsp_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_CMD_SEQ_STICKY_OVF_EN
  // Set has priority over clear when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n)                                 ovf_sticky <= 1'b0;
    else if (rsp_valid && rsp_ready && rsp_ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr)                           ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a behavioural ALU_8 model attached to the alu_* ports.
module tb_alu_cmd_sequencer;

  localparam int W     = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = '0;
  logic [W-1:0]     cmd_a = '0;
  logic [W-1:0]     cmd_b = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [W-1:0]     alu_a, alu_b, alu_result;
  logic [3:0]       alu_op;
  logic             alu_zero, alu_neg, alu_ovf;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_result;
  logic             rsp_zero, rsp_neg, rsp_ovf, rsp_err;
  logic [1:0]       state_dbg;
`ifdef ALU_CMD_SEQ_STICKY_OVF_EN
  logic             ovf_sticky;
  logic             ovf_clr = 1'b0;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [W-1:0] exp_q[$];

  alu_cmd_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_cnt    (cmd_cnt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .alu_ovf    (alu_ovf),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_neg    (rsp_neg),
    .rsp_ovf    (rsp_ovf),
    .rsp_err    (rsp_err),
`ifdef ALU_CMD_SEQ_STICKY_OVF_EN
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
`endif
    .state_dbg  (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // ALU_8 behavioural model
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_op)
      4'd0: begin
        alu_result = alu_a + alu_b;
        alu_ovf    = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      4'd1: begin
        alu_result = alu_b - alu_a;
        alu_ovf    = (alu_b[7] != alu_a[7]) && (alu_result[7] != alu_b[7]);
      end
      4'd2: begin
        alu_result = alu_a + 8'd1;
        alu_ovf    = (alu_a == 8'h7F);
      end
      4'd5:  alu_result = (alu_a == alu_b) ? 8'h00 : 8'h01;
      4'd6:  alu_result = {alu_b[6:0], 1'b0};
      4'd7:  alu_result = {alu_b[7], alu_b[7:1]};
      4'd8:  alu_result = ~alu_a;
      4'd9:  alu_result = alu_a & alu_b;
      4'd10: alu_result = alu_a | alu_b;
      4'd11: alu_result = ~(alu_a & alu_b);
      4'd12: alu_result = {alu_a[6:0], alu_a[7]};
      4'd13: alu_result = {alu_a[0], alu_a[7:1]};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
    alu_neg  = alu_result[7];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    if (obs === expv) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Drives one command; returns #1 after the handshake edge.
  task automatic send_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] cnt, input logic [7:0] exp_res);
    int t = 0;
    while (!cmd_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cnt = cnt; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    exp_q.push_back(exp_res);
  endtask

  // Latency counts edges from the handshake edge (inclusive) until rsp_valid is seen.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    while (!rsp_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic check_rsp(input string tag, input int lat, input int lat_exp,
                           input logic z, input logic n, input logic o, input logic e);
    logic [7:0] er;
    er = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    check({tag, "_valid"},  {31'd0, rsp_valid}, 32'd1);
    check({tag, "_lat"},    lat, lat_exp);
    check({tag, "_result"}, {24'd0, rsp_result}, {24'd0, er});
    check({tag, "_flags"},  {28'd0, rsp_zero, rsp_neg, rsp_ovf, rsp_err}, {28'd0, z, n, o, e});
  endtask

  task automatic take_rsp(input string tag);
    check({tag, "_ready_in_resp"}, {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_valid_after_hs"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_ready_after_hs"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu", {12'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("rst_rsp", {22'd0, rsp_result, rsp_zero, rsp_neg, rsp_ovf, rsp_err}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // rsp_ready while idle must do nothing
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_rsp_ready_state", {30'd0, state_dbg}, 32'd0);
    check("idle_rsp_ready_valid", {31'd0, rsp_valid}, 32'd0);

    // ADD 7F + 01 = 80, signed overflow
    send_cmd(4'd0, 8'h7F, 8'h01, 3'd0, 8'h80);
    wait_rsp(1, lat);
    check_rsp("add", lat, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    take_rsp("add");

    // SHL b=81 three passes: 81 -> 02 -> 04 -> 08
    send_cmd(4'd6, 8'h00, 8'h81, 3'd2, 8'h08);
    check("shl_b0", {24'd0, alu_b}, 32'h81);
    check("shl_st0", {30'd0, state_dbg}, 32'd1);
    @(posedge clk); #1;
    check("shl_b1", {24'd0, alu_b}, 32'h02);
    check("shl_st1", {30'd0, state_dbg}, 32'd1);
    @(posedge clk); #1;
    check("shl_b2", {24'd0, alu_b}, 32'h04);
    check("shl_st2", {30'd0, state_dbg}, 32'd1);
    wait_rsp(3, lat);
    check_rsp("shl", lat, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    take_rsp("shl");

    // ROR a=01 single pass
    send_cmd(4'd13, 8'h01, 8'h00, 3'd0, 8'h80);
    wait_rsp(1, lat);
    check_rsp("ror", lat, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    take_rsp("ror");

    // SHR b=80 two passes: C0 -> E0
    send_cmd(4'd7, 8'h00, 8'h80, 3'd1, 8'hE0);
    wait_rsp(1, lat);
    check_rsp("shr", lat, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    take_rsp("shr");

    // AND with nonzero count: count ignored, single pass
    send_cmd(4'd9, 8'hF0, 8'h3C, 3'd5, 8'h30);
    wait_rsp(1, lat);
    check_rsp("and_cnt", lat, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    take_rsp("and_cnt");

    // NAND FF,FF = 00 -> zero flag
    send_cmd(4'd11, 8'hFF, 8'hFF, 3'd0, 8'h00);
    wait_rsp(1, lat);
    check_rsp("nand", lat, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    take_rsp("nand");

    // ROL a=01 max count: 8 rotations return to 01
    send_cmd(4'd12, 8'h01, 8'h00, 3'd7, 8'h01);
    wait_rsp(1, lat);
    check_rsp("rol8", lat, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    take_rsp("rol8");

    // illegal opcodes go straight to RESP
    send_cmd(4'd3, 8'h12, 8'h34, 3'd0, 8'h00);
    check("ill3_no_exec", {30'd0, state_dbg}, 32'd2);
    wait_rsp(1, lat);
    check_rsp("ill3", lat, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    take_rsp("ill3");
    send_cmd(4'd15, 8'hFF, 8'h80, 3'd4, 8'h00);
    wait_rsp(1, lat);
    check_rsp("ill15", lat, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    take_rsp("ill15");

    // SUB 03 - 05 = FE with 5 cycles of backpressure
    send_cmd(4'd1, 8'h05, 8'h03, 3'd0, 8'hFE);
    wait_rsp(1, lat);
    check_rsp("sub", lat, 2, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {20'd0, rsp_valid, cmd_ready, rsp_result, rsp_zero, rsp_neg, rsp_ovf, rsp_err},
            {20'd0, 1'b1, 1'b0, 8'hFE, 4'b0100});
    end
    take_rsp("sub");

    // reset during the third EXEC pass of ROL cnt=7
    send_cmd(4'd12, 8'h81, 8'h00, 3'd7, 8'h00);
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_rst_in_exec", {30'd0, state_dbg}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid_rst_alu", {12'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("mid_rst_rsp", {22'd0, rsp_result, rsp_zero, rsp_neg, rsp_ovf, rsp_err}, 32'd0);
    check("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_rst", {31'd0, seen}, 32'd0);
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
